// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, ALU operation codes
// and the decoded control bundle handed to the EX stage.
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // All-zero word: the bubble loaded on reset and flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // ADD is code 0 so that an all-zero control bundle is a clean bubble
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_code_e;

    // Control bundle for EX/MEM/WB
    typedef struct packed {
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      mem_to_reg;
        logic      alu_src;
        logic      reg_dst;
        alu_code_e alu_code;
    } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, $0 hard-wired to zero, and write-to-read bypass so a value being
// written back this cycle is visible to the decode stage immediately.
module reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_en;

    assign wr_en = we && (waddr != 5'd0);

    // Next register contents: only the addressed entry changes on a write
    always_comb begin
        // NOTE: every always_comb output gets a full default first, so no path
        // leaves it unassigned and no latch is inferred.
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register storage with synchronous clear
    always_ff @(posedge clk) begin
        // NOTE: the whole array is cleared on reset because the pipeline relies on
        // every register reading 0 afterwards; this rules out a plain RAM macro.
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            regs_q <= regs_d;
        end
    end

    // Read ports: $0 first, then same-cycle bypass, then the array
    always_comb begin
        rdata1 = regs_q[raddr1];
        rdata2 = regs_q[raddr2];
        if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else if (wr_en && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
        if (raddr2 == 5'd0) begin
            rdata2 = '0;
        end else if (wr_en && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID pipeline register, register file,
// control decode, hazard detection, and branch/jump resolution in ID.
module id_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction_if,
    input  logic [31:0] PC,
    input  logic        IF_flush,
    input  logic        RegWrite_wb,
    input  logic [4:0]  WriteReg_wb,
    input  logic [31:0] WriteData_wb,
    input  logic        RegWrite_ex,
    input  logic        MemRead_ex,
    input  logic [4:0]  WriteReg_ex,
    input  logic        RegWrite_mem,
    input  logic        MemRead_mem,
    input  logic [4:0]  WriteReg_mem,
    input  logic [31:0] ALUResult_mem,
    output logic        IFWrite,
    output logic        Branch,
    output logic        Jump,
    output logic [31:0] JumpAddr,
    output logic [31:0] PC4_id,
    output logic [31:0] RsData,
    output logic [31:0] RtData,
    output logic [31:0] Imm32,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        ALUSrc,
    output logic        RegDst,
    output logic [3:0]  ALUCode
);

    // IF/ID pipeline register
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] instr_q, instr_d;

    // Decode results
    logic [5:0]  opcode;
    logic [5:0]  funct;
    ctrl_t       dec_ctrl;
    ctrl_t       ctrl_out;
    alu_code_e   r_alu;
    logic        r_valid;
    logic        zero_ext;
    logic        is_beq;
    logic        is_bne;
    logic        is_j;

    // Hazard and branch signals
    logic        stall;
    logic        load_use;
    logic        branch_stall;
    logic        ex_hits;
    logic        mem_load_hits;
    logic        fwd_rs;
    logic        fwd_rt;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic        operands_eq;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign opcode = instr_q[31:26];
    assign funct  = instr_q[5:0];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign shamt  = instr_q[10:6];
    assign PC4_id = pc4_q;

    // IF/ID next state: flush beats stall, stall holds, otherwise load from fetch
    always_comb begin
        pc4_d   = pc4_q;
        instr_d = instr_q;
        if (IF_flush) begin
            pc4_d   = '0;
            instr_d = NOP_INSTR;
        end else if (!stall) begin
            pc4_d   = PC + 32'd4;
            instr_d = Instruction_if;
        end
    end

    // IF/ID register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
        end
    end

    reg_file u_reg_file (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (RsData),
        .rdata2 (RtData),
        .we     (RegWrite_wb),
        .waddr  (WriteReg_wb),
        .wdata  (WriteData_wb)
    );

    // R-type function decode; unknown functs mark the word invalid
    always_comb begin
        r_alu   = ALU_ADD;
        r_valid = 1'b1;
        case (funct)
            F_ADD, F_ADDU: r_alu = ALU_ADD;
            F_SUB, F_SUBU: r_alu = ALU_SUB;
            F_AND:         r_alu = ALU_AND;
            F_OR:          r_alu = ALU_OR;
            F_XOR:         r_alu = ALU_XOR;
            F_NOR:         r_alu = ALU_NOR;
            F_SLT:         r_alu = ALU_SLT;
            F_SLTU:        r_alu = ALU_SLTU;
            F_SLL:         r_alu = ALU_SLL;
            F_SRL:         r_alu = ALU_SRL;
            F_SRA:         r_alu = ALU_SRA;
            default:       r_valid = 1'b0;
        endcase
    end

    // Main control decode; anything unrecognised stays an all-zero bubble
    always_comb begin
        dec_ctrl = '0;
        zero_ext = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                // The all-zero word would otherwise decode as sll $0 and raise RegWrite
                if (r_valid && (instr_q != NOP_INSTR)) begin
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.reg_dst   = 1'b1;
                    dec_ctrl.alu_code  = r_alu;
                end
            end
            OP_ADDI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_code  = ALU_ADD;
            end
            OP_SLTI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_code  = ALU_SLT;
            end
            OP_ANDI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_code  = ALU_AND;
                zero_ext           = 1'b1;
            end
            OP_ORI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_code  = ALU_OR;
                zero_ext           = 1'b1;
            end
            OP_LUI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_code  = ALU_LUI;
                zero_ext           = 1'b1;
            end
            OP_LW: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.alu_code   = ALU_ADD;
            end
            OP_SW: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_code  = ALU_ADD;
            end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_J:    is_j   = 1'b1;
            default: dec_ctrl = '0;
        endcase
    end

    assign Imm32 = zero_ext ? {16'b0, instr_q[15:0]}
                            : {{16{instr_q[15]}}, instr_q[15:0]};

    // Load-use: the EX load's destination is a source of the instruction in ID
    assign load_use = MemRead_ex && (WriteReg_ex != 5'd0) &&
                      ((WriteReg_ex == rs) || (WriteReg_ex == rt));

    // Branch operands not yet available: EX result pending, or MEM load pending
    assign ex_hits       = RegWrite_ex && (WriteReg_ex != 5'd0) &&
                           ((WriteReg_ex == rs) || (WriteReg_ex == rt));
    assign mem_load_hits = MemRead_mem && (WriteReg_mem != 5'd0) &&
                           ((WriteReg_mem == rs) || (WriteReg_mem == rt));
    assign branch_stall  = (is_beq || is_bne) && (ex_hits || mem_load_hits);

    assign stall   = load_use || branch_stall;
    assign IFWrite = ~stall;

    // Compare operands take a MEM-stage ALU result ahead of the register file
    assign fwd_rs = RegWrite_mem && !MemRead_mem && (WriteReg_mem != 5'd0) &&
                    (WriteReg_mem == rs);
    assign fwd_rt = RegWrite_mem && !MemRead_mem && (WriteReg_mem != 5'd0) &&
                    (WriteReg_mem == rt);
    assign cmp_a  = fwd_rs ? ALUResult_mem : RsData;
    assign cmp_b  = fwd_rt ? ALUResult_mem : RtData;
    assign operands_eq = (cmp_a == cmp_b);

    assign Branch = !stall && ((is_beq && operands_eq) || (is_bne && !operands_eq));
    assign Jump   = !stall && is_j;

    assign branch_target = PC4_id + (Imm32 << 2);
    assign jump_target   = {PC4_id[31:28], instr_q[25:0], 2'b00};
    assign JumpAddr      = Jump ? jump_target : branch_target;

    // A stalled instruction leaves ID as a bubble
    assign ctrl_out = stall ? '0 : dec_ctrl;
    assign RegWrite = ctrl_out.reg_write;
    assign MemRead  = ctrl_out.mem_read;
    assign MemWrite = ctrl_out.mem_write;
    assign MemtoReg = ctrl_out.mem_to_reg;
    assign ALUSrc   = ctrl_out.alu_src;
    assign RegDst   = ctrl_out.reg_dst;
    assign ALUCode  = ctrl_out.alu_code;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: the driver applies one directed vector per
// cycle and queues the expected responses; a negedge monitor pops them and
// compares against the DUT outputs.
module tb_id_stage;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] Instruction_if;
    logic [31:0] PC;
    logic        IF_flush;
    logic        RegWrite_wb;
    logic [4:0]  WriteReg_wb;
    logic [31:0] WriteData_wb;
    logic        RegWrite_ex;
    logic        MemRead_ex;
    logic [4:0]  WriteReg_ex;
    logic        RegWrite_mem;
    logic        MemRead_mem;
    logic [4:0]  WriteReg_mem;
    logic [31:0] ALUResult_mem;
    logic        IFWrite;
    logic        Branch;
    logic        Jump;
    logic [31:0] JumpAddr;
    logic [31:0] PC4_id;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic [31:0] Imm32;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        ALUSrc;
    logic        RegDst;
    logic [3:0]  ALUCode;

    typedef enum logic [3:0] {
        SIG_IFWRITE, SIG_BRANCH, SIG_JUMP, SIG_JADDR, SIG_RS, SIG_RT,
        SIG_CTRL, SIG_PC4, SIG_IMM, SIG_FIELDS
    } sig_e;

    typedef struct {
        string       name;
        sig_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    id_stage dut (
        .clk           (clk),
        .reset         (reset),
        .Instruction_if(Instruction_if),
        .PC            (PC),
        .IF_flush      (IF_flush),
        .RegWrite_wb   (RegWrite_wb),
        .WriteReg_wb   (WriteReg_wb),
        .WriteData_wb  (WriteData_wb),
        .RegWrite_ex   (RegWrite_ex),
        .MemRead_ex    (MemRead_ex),
        .WriteReg_ex   (WriteReg_ex),
        .RegWrite_mem  (RegWrite_mem),
        .MemRead_mem   (MemRead_mem),
        .WriteReg_mem  (WriteReg_mem),
        .ALUResult_mem (ALUResult_mem),
        .IFWrite       (IFWrite),
        .Branch        (Branch),
        .Jump          (Jump),
        .JumpAddr      (JumpAddr),
        .PC4_id        (PC4_id),
        .RsData        (RsData),
        .RtData        (RtData),
        .Imm32         (Imm32),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .shamt         (shamt),
        .RegWrite      (RegWrite),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .MemtoReg      (MemtoReg),
        .ALUSrc        (ALUSrc),
        .RegDst        (RegDst),
        .ALUCode       (ALUCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {OP_RTYPE, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {OP_J, target};
    endfunction

    // Expected-value packers: {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,ALUCode}
    function automatic logic [31:0] ctrl_v(input logic rw, input logic mr, input logic mw,
                                           input logic m2r, input logic as, input logic rdst,
                                           input alu_code_e alu);
        return {22'b0, rw, mr, mw, m2r, as, rdst, alu};
    endfunction

    function automatic logic [31:0] fields_v(input logic [4:0] s, input logic [4:0] t,
                                             input logic [4:0] d, input logic [4:0] sh);
        return {12'b0, s, t, d, sh};
    endfunction

    function automatic logic [31:0] actual(input sig_e sel);
        case (sel)
            SIG_IFWRITE: return {31'b0, IFWrite};
            SIG_BRANCH:  return {31'b0, Branch};
            SIG_JUMP:    return {31'b0, Jump};
            SIG_JADDR:   return JumpAddr;
            SIG_RS:      return RsData;
            SIG_RT:      return RtData;
            SIG_CTRL:    return {22'b0, RegWrite, MemRead, MemWrite, MemtoReg,
                                 ALUSrc, RegDst, ALUCode};
            SIG_PC4:     return PC4_id;
            SIG_IMM:     return Imm32;
            default:     return {12'b0, rs, rt, rd, shamt};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    task automatic expect_sig(input string name, input sig_e sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazards();
        RegWrite_wb   = 1'b0;
        WriteReg_wb   = 5'd0;
        WriteData_wb  = 32'h0;
        RegWrite_ex   = 1'b0;
        MemRead_ex    = 1'b0;
        WriteReg_ex   = 5'd0;
        RegWrite_mem  = 1'b0;
        MemRead_mem   = 1'b0;
        WriteReg_mem  = 5'd0;
        ALUResult_mem = 32'h0;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
        RegWrite_wb  = 1'b1;
        WriteReg_wb  = r;
        WriteData_wb = v;
    endtask

    // Monitor: compare everything queued for this cycle, away from the clock edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, actual(e.sel), e.val);
        end
        if (done) begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not terminate");
    end

    // Directed stimulus
    initial begin
        reset          = 1'b1;
        Instruction_if = 32'h0;
        PC             = 32'h0;
        IF_flush       = 1'b0;
        clear_hazards();

        // Two edges under reset: IF/ID cleared, outputs at reset values
        tick();
        tick();
        expect_sig("rst_ifwrite", SIG_IFWRITE, 32'd1);
        expect_sig("rst_branch",  SIG_BRANCH,  32'd0);
        expect_sig("rst_jump",    SIG_JUMP,    32'd0);
        expect_sig("rst_jaddr",   SIG_JADDR,   32'h0);
        expect_sig("rst_pc4",     SIG_PC4,     32'h0);
        expect_sig("rst_ctrl",    SIG_CTRL,    32'h0);
        expect_sig("rst_fields",  SIG_FIELDS,  32'h0);
        expect_sig("rst_imm",     SIG_IMM,     32'h0);
        reset          = 1'b0;
        Instruction_if = enc_r(5'd5, 5'd0, 5'd6, 5'd0, F_ADD);
        PC             = 32'h100;

        // add $6,$5,$0 in ID: $5 reads 0 after reset
        tick();
        expect_sig("rd5_rsdata",  SIG_RS,      32'h0);
        expect_sig("add_ctrl",    SIG_CTRL,    ctrl_v(1, 0, 0, 0, 0, 1, ALU_ADD));
        expect_sig("add_fields",  SIG_FIELDS,  fields_v(5'd5, 5'd0, 5'd6, 5'd0));
        expect_sig("add_pc4",     SIG_PC4,     32'h104);
        expect_sig("add_ifwrite", SIG_IFWRITE, 32'd1);
        Instruction_if = enc_r(5'd3, 5'd0, 5'd7, 5'd0, F_ADD);
        PC             = 32'h104;

        // Same-cycle WB bypass of $3
        tick();
        wb_write(5'd3, 32'h1234);
        expect_sig("wb_bypass_rs", SIG_RS, 32'h1234);
        Instruction_if = enc_r(5'd3, 5'd0, 5'd8, 5'd0, F_ADD);
        PC             = 32'h108;

        // $3 now stored; concurrent write to $0 must not bypass
        tick();
        wb_write(5'd0, 32'hFFFF);
        expect_sig("stored_rs3",    SIG_RS, 32'h1234);
        expect_sig("r0_no_bypass",  SIG_RT, 32'h0);
        Instruction_if = enc_r(5'd0, 5'd3, 5'd9, 5'd0, F_ADD);
        PC             = 32'h10C;

        // $0 still 0 after the write attempt; set $1 = 7 via WB
        tick();
        wb_write(5'd1, 32'd7);
        expect_sig("r0_reads_zero", SIG_RS, 32'h0);
        expect_sig("rt3_read",      SIG_RT, 32'h1234);
        Instruction_if = enc_i(OP_LW, 5'd1, 5'd2, 16'hFFFC);
        PC             = 32'h10C;

        // lw $2,-4($1) decode; $2 = 7 written this cycle (bypassed on rt)
        tick();
        wb_write(5'd2, 32'd7);
        expect_sig("lw_ctrl", SIG_CTRL, ctrl_v(1, 1, 0, 1, 1, 0, ALU_ADD));
        expect_sig("lw_imm",  SIG_IMM,  32'hFFFF_FFFC);
        expect_sig("lw_rs",   SIG_RS,   32'd7);
        expect_sig("lw_rt",   SIG_RT,   32'd7);
        expect_sig("lw_pc4",  SIG_PC4,  32'h110);
        Instruction_if = enc_r(5'd2, 5'd3, 5'd4, 5'd0, F_ADD);
        PC             = 32'h110;

        // Load-use: lw $2 in EX, add $4,$2,$3 in ID
        tick();
        clear_hazards();
        MemRead_ex  = 1'b1;
        RegWrite_ex = 1'b1;
        WriteReg_ex = 5'd2;
        expect_sig("lu_ifwrite", SIG_IFWRITE, 32'd0);
        expect_sig("lu_ctrl",    SIG_CTRL,    32'h0);
        expect_sig("lu_branch",  SIG_BRANCH,  32'd0);
        Instruction_if = enc_r(5'd1, 5'd2, 5'd10, 5'd0, F_SUB);
        PC             = 32'h114;

        // Bubble in EX; add held in IF/ID and now decodes normally
        tick();
        clear_hazards();
        expect_sig("lu_after_ifwrite", SIG_IFWRITE, 32'd1);
        expect_sig("lu_after_ctrl",    SIG_CTRL,    ctrl_v(1, 0, 0, 0, 0, 1, ALU_ADD));
        expect_sig("lu_held_fields",   SIG_FIELDS,  fields_v(5'd2, 5'd3, 5'd4, 5'd0));
        expect_sig("lu_held_pc4",      SIG_PC4,     32'h114);
        expect_sig("lu_after_rs",      SIG_RS,      32'd7);
        expect_sig("lu_after_rt",      SIG_RT,      32'h1234);

        // sub $10,$1,$2
        tick();
        expect_sig("sub_ctrl", SIG_CTRL, ctrl_v(1, 0, 0, 0, 0, 1, ALU_SUB));
        expect_sig("sub_pc4",  SIG_PC4,  32'h118);
        Instruction_if = enc_i(OP_BEQ, 5'd1, 5'd2, 16'd3);
        PC             = 32'h1C;

        // beq $1,$2,+3 at PC4_id 0x20: taken to 0x2C; fetch flushes
        tick();
        expect_sig("beq_branch",  SIG_BRANCH,  32'd1);
        expect_sig("beq_jump",    SIG_JUMP,    32'd0);
        expect_sig("beq_jaddr",   SIG_JADDR,   32'h2C);
        expect_sig("beq_ifwrite", SIG_IFWRITE, 32'd1);
        expect_sig("beq_ctrl",    SIG_CTRL,    32'h0);
        IF_flush       = 1'b1;
        Instruction_if = enc_i(OP_ORI, 5'd1, 5'd11, 16'h8000);
        PC             = 32'h20;

        // Flushed slot decodes as NOP
        tick();
        IF_flush = 1'b0;
        expect_sig("flush_fields", SIG_FIELDS, 32'h0);
        expect_sig("flush_imm",    SIG_IMM,    32'h0);
        expect_sig("flush_ctrl",   SIG_CTRL,   32'h0);
        expect_sig("flush_branch", SIG_BRANCH, 32'd0);
        PC = 32'h2C;

        // ori zero-extends
        tick();
        expect_sig("ori_ctrl", SIG_CTRL, ctrl_v(1, 0, 0, 0, 1, 0, ALU_OR));
        expect_sig("ori_imm",  SIG_IMM,  32'h0000_8000);
        Instruction_if = enc_i(OP_BNE, 5'd5, 5'd0, 16'h0010);
        PC             = 32'h40;

        // bne $5,$0 with MEM ALU result 1 forwarded: taken
        tick();
        RegWrite_mem  = 1'b1;
        WriteReg_mem  = 5'd5;
        ALUResult_mem = 32'd1;
        expect_sig("fwd_branch",  SIG_BRANCH,  32'd1);
        expect_sig("fwd_jaddr",   SIG_JADDR,   32'h84);
        expect_sig("fwd_rsdata",  SIG_RS,      32'h0);
        expect_sig("fwd_ifwrite", SIG_IFWRITE, 32'd1);

        // Same bne with $5 produced by EX: stall
        tick();
        clear_hazards();
        RegWrite_ex = 1'b1;
        WriteReg_ex = 5'd5;
        expect_sig("bex_ifwrite", SIG_IFWRITE, 32'd0);
        expect_sig("bex_branch",  SIG_BRANCH,  32'd0);

        // Held bne, no hazards: $5 == $0 so not taken
        tick();
        clear_hazards();
        expect_sig("bne_nt_branch",  SIG_BRANCH,  32'd0);
        expect_sig("bne_nt_ifwrite", SIG_IFWRITE, 32'd1);

        // bne with $5 loaded in MEM: stall, no forwarding from a load
        tick();
        RegWrite_mem  = 1'b1;
        MemRead_mem   = 1'b1;
        WriteReg_mem  = 5'd5;
        ALUResult_mem = 32'd1;
        expect_sig("bmem_ifwrite", SIG_IFWRITE, 32'd0);
        expect_sig("bmem_branch",  SIG_BRANCH,  32'd0);
        Instruction_if = enc_j(26'h0000040);
        PC             = 32'h3000_0000;

        // Hazard gone; bne still held and not taken
        tick();
        clear_hazards();
        expect_sig("bmem_after_branch", SIG_BRANCH, 32'd0);

        // j 0x40 with PC4_id 0x30000004
        tick();
        expect_sig("j_jump",   SIG_JUMP,   32'd1);
        expect_sig("j_jaddr",  SIG_JADDR,  32'h3000_0100);
        expect_sig("j_branch", SIG_BRANCH, 32'd0);
        expect_sig("j_ctrl",   SIG_CTRL,   32'h0);
        expect_sig("j_pc4",    SIG_PC4,    32'h3000_0004);
        Instruction_if = 32'hFC00_0000;

        // Unsupported opcode decodes as NOP
        tick();
        expect_sig("badop_ctrl",    SIG_CTRL,    32'h0);
        expect_sig("badop_jump",    SIG_JUMP,    32'd0);
        expect_sig("badop_ifwrite", SIG_IFWRITE, 32'd1);
        Instruction_if = enc_i(OP_LUI, 5'd0, 5'd12, 16'hABCD);

        // lui
        tick();
        expect_sig("lui_ctrl", SIG_CTRL, ctrl_v(1, 0, 0, 0, 1, 0, ALU_LUI));
        expect_sig("lui_imm",  SIG_IMM,  32'h0000_ABCD);
        Instruction_if = enc_r(5'd0, 5'd2, 5'd13, 5'd5, F_SRA);

        // sra $13,$2,5
        tick();
        expect_sig("sra_ctrl",   SIG_CTRL,   ctrl_v(1, 0, 0, 0, 0, 1, ALU_SRA));
        expect_sig("sra_fields", SIG_FIELDS, fields_v(5'd0, 5'd2, 5'd13, 5'd5));

        // Load-use stall on rt, with reset asserted for the coming edge
        tick();
        MemRead_ex  = 1'b1;
        WriteReg_ex = 5'd2;
        expect_sig("rs_stall_ifwrite", SIG_IFWRITE, 32'd0);
        expect_sig("rs_stall_ctrl",    SIG_CTRL,    32'h0);
        reset = 1'b1;

        // After mid-stall reset: IF/ID cleared
        tick();
        reset = 1'b0;
        clear_hazards();
        expect_sig("mrst_fields",  SIG_FIELDS,  32'h0);
        expect_sig("mrst_pc4",     SIG_PC4,     32'h0);
        expect_sig("mrst_ctrl",    SIG_CTRL,    32'h0);
        expect_sig("mrst_ifwrite", SIG_IFWRITE, 32'd1);
        Instruction_if = enc_r(5'd1, 5'd2, 5'd14, 5'd0, F_ADD);
        PC             = 32'h50;

        // Register file cleared: $1 and $2 read 0
        tick();
        expect_sig("mrst_rs1", SIG_RS,  32'h0);
        expect_sig("mrst_rt2", SIG_RT,  32'h0);
        expect_sig("mrst_pc4b", SIG_PC4, 32'h54);
        done = 1'b1;
    end

endmodule
